// File: rtl/vx_tensor_mac_unit.sv
// vx_tensor_mac_unit
//   Sequential DIM x DIM matrix multiply-accumulate unit: C = A*B or C += A*B.
//   A and B are streamed in as element pairs in row-major order. The unit then
//   performs one MAC per cycle for DIM^3 cycles and streams C out in row-major
//   order. C persists between operations, so accumulate=1 chains results.
//
// Ports
//   clk        i  sole clock, rising edge
//   reset      i  asynchronous, active-high
//   start      i  operation request, sampled only in IDLE
//   accumulate i  mode sampled with start: 1 = C+=A*B, 0 = C=A*B
//   busy       o  high whenever the unit is not IDLE
//   in_valid   i  A/B element pair valid
//   in_a       i  element of A (row-major)
//   in_b       i  element of B (row-major)
//   in_ready   o  pair accepted this cycle when in_valid is high (LOAD only)
//   out_valid  o  out_data holds a C element (STORE only)
//   out_data   o  element of C (row-major), zero outside STORE
//   out_ready  i  consumer accepts out_data
//   done       o  one-cycle pulse after the last C element is taken
module vx_tensor_mac_unit #(
  parameter int unsigned DIM   = 2,
  parameter int unsigned DATAW = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             accumulate,
  output logic             busy,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_a,
  input  logic [DATAW-1:0] in_b,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready,
  output logic             done
);

  localparam int unsigned NumElem = DIM * DIM;
  localparam int unsigned IdxW    = $clog2(NumElem);
  localparam int unsigned LoopW   = $clog2(DIM);

  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NumElem - 1);
  localparam logic [LoopW-1:0] LastLoop = LoopW'(DIM - 1);
  localparam logic [IdxW-1:0]  DimIdx   = IdxW'(DIM);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StExec,
    StStore
  } state_e;

  state_e           state_q;
  logic             acc_q;        // latched accumulate mode
  logic             first_q;      // first EXEC cycle: conditional clear of C
  logic [IdxW-1:0]  idx_q;        // element counter for LOAD and STORE
  logic [LoopW-1:0] i_q, j_q, k_q;
  logic             busy_q, in_ready_q, out_valid_q, done_q;

  logic [DATAW-1:0] a_q [NumElem];
  logic [DATAW-1:0] b_q [NumElem];
  logic [DATAW-1:0] c_q [NumElem];

  logic [IdxW-1:0]  a_sel, b_sel, c_sel;
  logic [DATAW-1:0] prod;
  logic [DATAW-1:0] c_base;
  logic [DATAW-1:0] mac_sum;
  logic             exec_last;

  // MAC datapath: C[i][j] += A[i][k] * B[k][j]. Product truncates to DATAW and
  // the sum wraps; on the first EXEC cycle of a non-accumulating operation the
  // old C[0][0] is replaced by zero so the clear and the first MAC share a cycle.
  always_comb begin
    a_sel     = IdxW'(i_q) * DimIdx + IdxW'(k_q);
    b_sel     = IdxW'(k_q) * DimIdx + IdxW'(j_q);
    c_sel     = IdxW'(i_q) * DimIdx + IdxW'(j_q);
    prod      = a_q[a_sel] * b_q[b_sel];
    c_base    = (first_q && !acc_q) ? '0 : c_q[c_sel];
    mac_sum   = c_base + prod;
    exec_last = (i_q == LastLoop) && (j_q == LastLoop) && (k_q == LastLoop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= 1'b0;
      first_q     <= 1'b0;
      idx_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int e = 0; e < int'(NumElem); e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
        c_q[e] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            acc_q      <= accumulate;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= StLoad;
          end
        end

        StLoad: begin
          if (in_valid && in_ready_q) begin
            a_q[idx_q] <= in_a;
            b_q[idx_q] <= in_b;
            if (idx_q == LastIdx) begin
              idx_q      <= '0;
              in_ready_q <= 1'b0;
              first_q    <= 1'b1;
              i_q        <= '0;
              j_q        <= '0;
              k_q        <= '0;
              state_q    <= StExec;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        StExec: begin
          first_q <= 1'b0;
          if (first_q && !acc_q) begin
            for (int e = 0; e < int'(NumElem); e++) begin
              c_q[e] <= '0;
            end
          end
          // Later assignment wins over the clear above for the active element.
          c_q[c_sel] <= mac_sum;
          // k innermost, then j, then i.
          if (k_q == LastLoop) begin
            k_q <= '0;
            if (j_q == LastLoop) begin
              j_q <= '0;
              i_q <= i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
          if (exec_last) begin
            i_q         <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= StStore;
          end
        end

        StStore: begin
          if (out_ready) begin
            if (idx_q == LastIdx) begin
              idx_q       <= '0;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= StIdle;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  // C is stable during STORE, so the selected element holds until handshake.
  assign out_data  = out_valid_q ? c_q[idx_q] : '0;

endmodule

// File: tb/tb_vx_tensor_mac_unit.sv
module tb_vx_tensor_mac_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        accumulate = 1'b0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic        done;

  int tests = 0;
  int fails = 0;

  logic [31:0] va [4];
  logic [31:0] vb [4];
  logic [31:0] exp_c [4];

  always #5 clk = ~clk;

  vx_tensor_mac_unit #(.DIM(2), .DATAW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .accumulate (accumulate),
    .busy       (busy),
    .in_valid   (in_valid),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".out_data"}, out_data, 32'd0);
  endtask

  task automatic begin_op(input logic acc, input string tag);
    start      = 1'b1;
    accumulate = acc;
    step();
    start      = 1'b0;
    check({tag, ".busy_rise"}, 32'(busy), 32'd1);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic load_all(input string tag);
    for (int e = 0; e < 4; e++) begin
      in_valid = 1'b1;
      in_a     = va[e];
      in_b     = vb[e];
      step();
    end
    in_valid = 1'b0;
    check({tag, ".in_ready_low"}, 32'(in_ready), 32'd0);
  endtask

  // Counts cycles from the last input handshake to out_valid; optional start
  // pulse while busy must be ignored.
  task automatic wait_exec(input bit pulse_start, input string tag);
    int cnt = 0;
    while (!out_valid && cnt < 40) begin
      start = (pulse_start && cnt == 2);
      step();
      cnt++;
    end
    start = 1'b0;
    check({tag, ".latency"}, 32'(cnt), 32'd8);
  endtask

  // Drains C; with use_pat, out_ready follows 1,0,0,1,0,1,1 (cyclic).
  task automatic drain(input bit use_pat, input string tag);
    logic [6:0] pat = 7'b1101001;  // bit g is cycle g
    int n = 0;
    int g = 0;
    logic rdy;
    while (n < 4 && g < 40) begin
      rdy = use_pat ? pat[g % 7] : 1'b1;
      out_ready = rdy;
      check($sformatf("%s.valid%0d", tag, n), 32'(out_valid), 32'd1);
      check($sformatf("%s.c%0d", tag, n), out_data, exp_c[n]);
      step();
      if (rdy) n++;
      g++;
    end
    out_ready = 1'b0;
    check({tag, ".count"}, 32'(n), 32'd4);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".busy_fall"}, 32'(busy), 32'd0);
    check({tag, ".valid_low"}, 32'(out_valid), 32'd0);
    step();
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check_quiet("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Op 1: C = A*B, start pulsed while busy
    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd5, 32'd6, 32'd7, 32'd8};
    exp_c = '{32'd19, 32'd22, 32'd43, 32'd50};
    begin_op(1'b0, "op1");
    load_all("op1");
    wait_exec(1'b1, "op1");
    drain(1'b0, "op1");
    step();
    step();
    check_quiet("op1.idle");

    // Op 2: C += A*B, back-pressured output
    exp_c = '{32'd38, 32'd44, 32'd86, 32'd100};
    begin_op(1'b1, "op2");
    load_all("op2");
    wait_exec(1'b0, "op2");
    drain(1'b1, "op2");

    // Op 3: truncation of product
    va = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    vb = '{32'd2, 32'd0, 32'd0, 32'd0};
    exp_c = '{32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0};
    begin_op(1'b0, "op3");
    load_all("op3");
    wait_exec(1'b0, "op3");
    drain(1'b0, "op3");

    // Reset mid-LOAD, then a fresh accumulate op must see C cleared
    va = '{32'd9, 32'd9, 32'd9, 32'd9};
    vb = '{32'd9, 32'd9, 32'd9, 32'd9};
    begin_op(1'b1, "op4");
    for (int e = 0; e < 2; e++) begin
      in_valid = 1'b1;
      in_a     = va[e];
      in_b     = vb[e];
      step();
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_quiet("midreset");
    step();
    reset = 1'b0;
    va = '{32'd1, 32'd2, 32'd3, 32'd4};
    vb = '{32'd5, 32'd6, 32'd7, 32'd8};
    exp_c = '{32'd19, 32'd22, 32'd43, 32'd50};
    begin_op(1'b1, "op5");
    load_all("op5");
    wait_exec(1'b0, "op5");
    drain(1'b0, "op5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vx_tensor_mac_unit.md
VX_TENSOR_MAC_UNIT -- requirements
Module: VX_tensor_mac_unit

Interface
REQ-001 SHALL have parameter DIM, default 2, meaning square matrix dimension; legal range 2..8.
REQ-002 SHALL have parameter DATAW, default 32, meaning element width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request for one matrix operation; sampled only in IDLE.
REQ-006 SHALL have port accumulate  input  1  mode, sampled with start: 1 = C+=A*B, 0 = C=A*B.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port in_valid  input  1  A/B element pair valid.
REQ-009 SHALL have port in_a  input  DATAW  element of A, row-major order.
REQ-010 SHALL have port in_b  input  DATAW  element of B, row-major order.
REQ-011 SHALL have port in_ready  output  1  unit accepts a pair; high only in LOAD.
REQ-012 SHALL have port out_valid  output  1  out_data holds a C element; high only in STORE.
REQ-013 SHALL have port out_data  output  DATAW  C element, row-major order.
REQ-014 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-015 SHALL have port done  output  1  one-cycle pulse on operation completion.

Function
REQ-016 SHALL implement states IDLE, LOAD, EXEC, STORE holding A, B, C as DIM*DIM DATAW-bit register arrays.
REQ-017 IDLE: start=1 SHALL latch accumulate, clear element counter, enter LOAD next cycle; start outside IDLE SHALL be ignored.
REQ-018 LOAD: each cycle with in_valid & in_ready SHALL write A[idx], B[idx] and increment idx; after idx DIM*DIM-1 accepted, SHALL enter EXEC next cycle with in_ready low.
REQ-019 LOAD SHALL wait indefinitely with in_valid low; no timeout.
REQ-020 EXEC first cycle SHALL zero C if latched accumulate=0, else keep prior C, and begin MACs in the same cycle.
REQ-021 EXEC SHALL perform exactly one MAC per cycle, C[i][j] += A[i][k]*B[k][j], k innermost then j then i, for exactly DIM^3 cycles.
REQ-022 Product SHALL be unsigned, truncated to low DATAW bits; accumulation SHALL wrap modulo 2^DATAW; no saturation, no overflow flag.
REQ-023 After the last MAC, SHALL enter STORE next cycle with out_valid=1, out_data=C[0][0].
REQ-024 STORE: out_data SHALL stay stable while out_valid & ~out_ready; each out_valid & out_ready SHALL advance to next element.
REQ-025 On handshake of element DIM*DIM-1, SHALL enter IDLE next cycle and pulse done=1 for that one cycle.
REQ-026 C SHALL persist in IDLE across operations so accumulate=1 chains results.
REQ-027 Element and loop counters SHALL be sized $clog2(DIM*DIM) / $clog2(DIM) and SHALL never index beyond DIM*DIM-1.
REQ-028 busy SHALL rise the cycle after start is accepted and fall the cycle done pulses.

Reset
REQ-029 Reset asserted at any time, including mid-LOAD/EXEC/STORE, SHALL immediately force IDLE, clear A, B, C, all counters, and latched mode.
REQ-030 During and after reset, busy, in_ready, out_valid, done SHALL be 0 and out_data SHALL be 0.
REQ-031 First start after reset release SHALL be honored on the first rising edge with reset low.

Verification
REQ-032 DIM=2, accumulate=0, A=[1,2,3,4], B=[5,6,7,8], out_ready=1 -> out_data 19,22,43,50; out_valid exactly 8 cycles after last input handshake; done one cycle after last output.
REQ-033 Repeat REQ-032 with accumulate=1 and same A, B -> 38,44,86,100.
REQ-034 Inputs 0xFFFFFFFF in A[0], 2 in B[0], all others 0, accumulate=0 -> C[0][0]=0xFFFFFFFE, rest 0.
REQ-035 out_ready toggled 1,0,0,1,0,1,1 during STORE -> each element held stable until handshake; no loss or duplication.
REQ-036 Reset asserted after 2 LOAD handshakes, then new full operation -> outputs match fresh computation; start pulsed while busy -> ignored, no second operation.
